// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file and the core pipeline that uses it.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    function automatic int reg_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/issue/write-back bundle between the pipeline (master) and the register file (slave).
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2
);
    localparam int AW = reg_aw(NREG);

    logic [NRD*AW-1:0]   rs;
    logic [NRD*XLEN-1:0] read_data;
    logic [NRD-1:0]      rs_busy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic                wb_valid;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic                wb_underflow;

    modport master (
        output rs, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, flush,
        input  read_data, rs_busy, issue_ready, wb_underflow
    );

    modport slave (
        input  rs, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, flush,
        output read_data, rs_busy, issue_ready, wb_underflow
    );

endinterface

// File: rtl/sb_pending_counter.sv
// Outstanding-write counter for one architectural register; callers guarantee
// inc is never asserted when full and dec never when zero.
module sb_pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             nonzero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign full    = &cnt_q;
    assign nonzero = |cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one write-back port with bypass,
// and a per-register pending-write scoreboard. r0 reads zero and is never busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NRD   = 2,
    parameter int CNT_W = 2
) (
    input logic         clk,
    input logic         resetn,
    regfile_sb_if.slave bus
);

    localparam int            AW = reg_aw(NREG);
    localparam logic [AW-1:0] R0 = AW'(REG_ZERO);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] cnt    [NREG];
    logic [NREG-1:0]  full;
    logic [NREG-1:0]  nonzero;
    logic             wb_en;
    logic             wb_underflow_q, wb_underflow_d;

    assign wb_en = bus.wb_valid && (bus.wb_rd != R0);

    // r0 has no counter: it is never full, never pending.
    assign cnt[0]     = '0;
    assign full[0]    = 1'b0;
    assign nonzero[0] = 1'b0;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_cnt
            logic inc, dec;
            assign inc = bus.issue_valid && bus.issue_ready && (bus.issue_rd == AW'(r));
            assign dec = bus.wb_valid && (bus.wb_rd == AW'(r)) && nonzero[r];

            sb_pending_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk     (clk),
                .resetn  (resetn),
                .inc     (inc),
                .dec     (dec),
                .clr     (bus.flush),
                .cnt     (cnt[r]),
                .full    (full[r]),
                .nonzero (nonzero[r])
            );
        end
    endgenerate

    assign bus.issue_ready = (bus.issue_rd == R0) || !full[bus.issue_rd];

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[bus.wb_rd] = bus.wb_data;
        end
    end

    always_comb begin
        wb_underflow_d = wb_underflow_q
                       | (wb_en && !nonzero[bus.wb_rd] && !bus.flush);
    end

    // NOTE: the data array is reset explicitly because software may read any register right after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wb_underflow_q <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            wb_underflow_q <= wb_underflow_d;
        end
    end

    assign bus.wb_underflow = wb_underflow_q;

    // A write-back retiring the last pending write both bypasses its data and clears busy.
    always_comb begin
        bus.read_data = '0;
        bus.rs_busy   = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] idx;
            logic          hit;
            idx = bus.rs[k*AW +: AW];
            hit = bus.wb_valid && (bus.wb_rd == idx);
            if (idx == R0) begin
                bus.read_data[k*XLEN +: XLEN] = '0;
            end else if (hit) begin
                bus.read_data[k*XLEN +: XLEN] = bus.wb_data;
            end else begin
                bus.read_data[k*XLEN +: XLEN] = regs_q[idx];
            end
            bus.rs_busy[k] = nonzero[idx] && !(hit && (cnt[idx] == CNT_W'(1)));
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then random traffic against
// an array/integer reference model of registers and pending-write counts.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int CNT_W = 2;
    localparam int AW    = 5;
    localparam int MAXP  = (1 << CNT_W) - 1;

    typedef struct {
        bit              resetn;
        int              rs0;
        int              rs1;
        bit              iv;
        int              ird;
        bit              wbv;
        int              wbrd;
        logic [XLEN-1:0] wbd;
        bit              flush;
    } stim_t;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] rd0;
        logic [XLEN-1:0] rd1;
        logic [1:0]      busy;
        logic            ready;
        logic            ufl;
    } exp_t;

    logic clk;
    logic resetn;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [XLEN-1:0] m_reg [NREG];
    int              m_cnt [NREG];
    bit              m_ufl;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.resetn = 1'b1;
        s.rs0 = 0; s.rs1 = 0;
        s.iv = 1'b0; s.ird = 0;
        s.wbv = 1'b0; s.wbrd = 0; s.wbd = '0;
        s.flush = 1'b0;
        return s;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input int idx, input stim_t s);
        if (idx == 0) return '0;
        if (s.wbv && s.wbrd == idx) return s.wbd;
        return m_reg[idx];
    endfunction

    function automatic logic m_busy(input int idx, input stim_t s);
        if (idx == 0 || m_cnt[idx] == 0) return 1'b0;
        return !(s.wbv && s.wbrd == idx && m_cnt[idx] == 1);
    endfunction

    // Drive one cycle, predict outputs, then advance the model across the edge.
    task automatic step(input stim_t s, input string tag);
        exp_t e;
        bit   ready, acc;
        resetn          = s.resetn;
        bus.rs          = {AW'(s.rs1), AW'(s.rs0)};
        bus.issue_valid = s.iv;
        bus.issue_rd    = AW'(s.ird);
        bus.wb_valid    = s.wbv;
        bus.wb_rd       = AW'(s.wbrd);
        bus.wb_data     = s.wbd;
        bus.flush       = s.flush;

        ready   = (s.ird == 0) || (m_cnt[s.ird] < MAXP);
        e.tag   = tag;
        e.rd0   = m_read(s.rs0, s);
        e.rd1   = m_read(s.rs1, s);
        e.busy  = {m_busy(s.rs1, s), m_busy(s.rs0, s)};
        e.ready = ready;
        e.ufl   = m_ufl;
        exp_q.push_back(e);

        if (!s.resetn) begin
            for (int r = 0; r < NREG; r++) begin
                m_reg[r] = '0;
                m_cnt[r] = 0;
            end
            m_ufl = 1'b0;
        end else begin
            acc = s.iv && ready;
            if (s.wbv && s.wbrd != 0 && m_cnt[s.wbrd] == 0 && !s.flush) m_ufl = 1'b1;
            for (int r = 1; r < NREG; r++) begin
                int delta;
                delta = 0;
                if (acc && s.ird == r) delta++;
                if (s.wbv && s.wbrd == r && m_cnt[r] > 0) delta--;
                m_cnt[r] = s.flush ? 0 : m_cnt[r] + delta;
            end
            if (s.wbv && s.wbrd != 0) m_reg[s.wbrd] = s.wbd;
        end

        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".rd0"},   bus.read_data[XLEN-1:0],      e.rd0);
                check({e.tag, ".rd1"},   bus.read_data[2*XLEN-1:XLEN], e.rd1);
                check({e.tag, ".busy"},  XLEN'(bus.rs_busy),           XLEN'(e.busy));
                check({e.tag, ".ready"}, XLEN'(bus.issue_ready),       XLEN'(e.ready));
                check({e.tag, ".ufl"},   XLEN'(bus.wb_underflow),      XLEN'(e.ufl));
            end
        end
    end

    initial begin
        stim_t s;
        int    pend[$];
        int    wait_cycles;

        for (int r = 0; r < NREG; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        m_ufl = 1'b0;

        s = idle();
        s.resetn = 1'b0;
        resetn          = 1'b0;
        bus.rs          = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
        @(posedge clk);
        #1;

        // Reset then read
        s = idle(); s.resetn = 1'b0; s.rs0 = 5; step(s, "reset_rd");
        s = idle(); s.rs0 = 5; step(s, "post_reset");

        // Issue, busy, write-back bypass
        s = idle(); s.iv = 1; s.ird = 5; s.rs0 = 5; step(s, "issue_r5");
        s = idle(); s.rs0 = 5; step(s, "busy_r5");
        s = idle(); s.rs0 = 5; s.wbv = 1; s.wbrd = 5; s.wbd = 32'hDEADBEEF; step(s, "wb_bypass_r5");
        s = idle(); s.rs0 = 5; s.rs1 = 5; step(s, "after_wb_r5");

        // Zero register
        s = idle(); s.wbv = 1; s.wbrd = 0; s.wbd = 32'h1234; s.iv = 1; s.ird = 0; step(s, "r0_wr_issue");
        s = idle(); s.rs0 = 0; s.rs1 = 0; s.ird = 0; step(s, "r0_read");

        // Saturation on r7
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.iv = 1; s.ird = 7; s.rs0 = 7; step(s, "issue_r7");
        end
        s = idle(); s.iv = 1; s.ird = 7; s.rs0 = 7; step(s, "issue_r7_full");
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.wbv = 1; s.wbrd = 7; s.wbd = 32'h700 + i; s.rs0 = 7;
            s.iv = (i == 0); s.ird = 7;
            step(s, "wb_r7");
        end
        s = idle(); s.rs0 = 7; s.ird = 7; step(s, "r7_drained");

        // Simultaneous issue/wb, then flush
        s = idle(); s.iv = 1; s.ird = 3; step(s, "issue_r3");
        s = idle(); s.iv = 1; s.ird = 3; s.wbv = 1; s.wbrd = 3; s.wbd = 32'h33; s.rs0 = 3; step(s, "issue_wb_r3");
        s = idle(); s.iv = 1; s.ird = 10; s.rs0 = 3; step(s, "r3_still_busy");
        s = idle(); s.flush = 1; s.wbv = 1; s.wbrd = 9; s.wbd = 32'h55; s.rs0 = 9; s.rs1 = 3; step(s, "flush_wb_r9");
        s = idle(); s.rs0 = 9; s.rs1 = 3; step(s, "after_flush");
        s = idle(); s.rs0 = 10; s.rs1 = 9; step(s, "after_flush2");

        // Underflow, then reset with a pending write
        s = idle(); s.wbv = 1; s.wbrd = 4; s.wbd = 32'h44; s.rs0 = 4; step(s, "wb_r4_underflow");
        s = idle(); s.rs0 = 4; step(s, "ufl_set");
        s = idle(); s.iv = 1; s.ird = 2; step(s, "issue_r2");
        s = idle(); s.rs0 = 2; s.rs1 = 4; step(s, "ufl_sticky");
        s = idle(); s.resetn = 1'b0; s.rs0 = 2; step(s, "mid_reset");
        s = idle(); s.rs0 = 2; s.rs1 = 5; step(s, "after_reset");

        // Random traffic concentrated on r0..r7 to provoke hazards
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.resetn = ($urandom_range(0, 99) != 0);
            s.iv     = $urandom_range(0, 1);
            s.ird    = $urandom_range(0, 7);
            s.wbv    = ($urandom_range(0, 2) != 0);
            pend.delete();
            for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) pend.push_back(r);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                s.wbrd = pend[$urandom_range(0, pend.size() - 1)];
            else
                s.wbrd = $urandom_range(0, 7);
            s.wbd    = $urandom;
            s.flush  = ($urandom_range(0, 31) == 0);
            s.rs0    = ($urandom_range(0, 3) == 0) ? s.wbrd : int'($urandom_range(0, 7));
            s.rs1    = ($urandom_range(0, 3) == 0) ? s.ird  : int'($urandom_range(0, 7));
            step(s, "rand");
        end

        s = idle();
        resetn = 1'b1;
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.flush       = 1'b0;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
